sd_init_fsm: RTL and testbench

- Command sequencer that sits directly upstream of the SD transceiver.
- After power-up it drives the transceiver's start/index/argument/clock-select inputs and consumes its response/valid/CRC outputs.
- It runs the SD card identification sequence: CMD0, CMD8, CMD55+ACMD41 loop, CMD2, CMD3, CMD7.
- On success it switches the bus to the fast clock and reports the card RCA and capacity type to the data-path controller.

---
 rtl/sd_init_fsm_pkg.sv | 52 +++++
 rtl/sd_init_fsm_if.sv | 30 +++
 rtl/sd_init_fsm_timer.sv | 26 ++
 rtl/sd_init_fsm.sv | 244 ++++++++++++++++++++++++
 tb/tb_sd_init_fsm.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_init_fsm_pkg.sv
// Shared types and constants for the SD card identification sequencer.
// Holds the step/state enums, command indices, CMD8 argument and error codes.
package sd_pkg;

    typedef enum logic [2:0] {
        S_CMD0,
        S_CMD8,
        S_CMD55,
        S_ACMD41,
        S_CMD2,
        S_CMD3,
        S_CMD7
    } step_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ERROR
    } state_t;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD2   = 6'd2;
    localparam logic [5:0] CMD3   = 6'd3;
    localparam logic [5:0] CMD7   = 6'd7;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam logic [31:0] CMD8_ARG = 32'h0000_01AA;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_CRC     = 3'd2;
    localparam logic [2:0] ERR_ECHO    = 3'd3;
    localparam logic [2:0] ERR_ACMD41  = 3'd4;

    function automatic logic [5:0] cmd_index(step_t s);
        case (s)
            S_CMD0:   return CMD0;
            S_CMD8:   return CMD8;
            S_CMD55:  return CMD55;
            S_ACMD41: return ACMD41;
            S_CMD2:   return CMD2;
            S_CMD3:   return CMD3;
            S_CMD7:   return CMD7;
            default:  return CMD0;
        endcase
    endfunction

endpackage

// File: rtl/sd_init_fsm_if.sv
// Bundle between the init sequencer, the SD transceiver and the data-path controller.
// master = sequencer side, slave = transceiver/controller side.
interface sd_init_fsm_if;
    logic        istart;
    logic        ostart;
    logic        osel_clk;
    logic [5:0]  ocmd_index;
    logic [31:0] ocmd_arg;
    logic [31:0] iresp;
    logic        icrc_fail;
    logic        ivalid;
    logic        obusy;
    logic        odone;
    logic        oerror;
    logic [2:0]  oerr_code;
    logic [15:0] orca;
    logic        ohcs;

    modport master (
        input  istart, iresp, icrc_fail, ivalid,
        output ostart, osel_clk, ocmd_index, ocmd_arg,
               obusy, odone, oerror, oerr_code, orca, ohcs
    );

    modport slave (
        output istart, iresp, icrc_fail, ivalid,
        input  ostart, osel_clk, ocmd_index, ocmd_arg,
               obusy, odone, oerror, oerr_code, orca, ohcs
    );
endinterface

// File: rtl/sd_init_fsm_timer.sv
// Loadable up-counter with a terminal-count flag; holds at the terminal value.
// Shared by the CMD0 settle wait and the response timeout.
module sd_timer #(
    parameter int WIDTH = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_terminal,
    output logic             o_tc
);
    logic [WIDTH-1:0] r_count;

    assign o_tc = (r_count == i_terminal);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/sd_init_fsm.sv
// SD card identification sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7.
// Optional macro SD_INIT_RETRY_EN: up to 3 re-issues of a step on timeout or CRC error.
module sd_init_fsm
    import sd_pkg::*;
#(
    parameter int          RESP_TIMEOUT = 4096,
    parameter int          CMD0_WAIT    = 64,
    parameter int          ACMD41_TRIES = 1000,
    parameter logic [31:0] ACMD41_ARG   = 32'h40FF_8000
) (
    input logic          iclk,
    input logic          irst,
    sd_init_fsm_if.master bus
);
    localparam int TIMER_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam int TRY_W   = (ACMD41_TRIES > 1) ? $clog2(ACMD41_TRIES) : 1;

    state_t              r_state;
    step_t               r_step;
    logic                r_ostart;
    logic                r_sel_clk;
    logic [5:0]          r_cmd_index;
    logic [31:0]         r_cmd_arg;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [2:0]          r_err_code;
    logic [15:0]         r_rca;
    logic                r_hcs;
    logic [TRY_W-1:0]    r_try;

    logic                w_tc;
    logic [TIMER_W-1:0]  w_terminal;
    logic                w_start;
    logic                w_issue;
    step_t               w_next_step;
    logic [31:0]         w_next_arg;
    logic                w_fail;
    logic [2:0]          w_code;
    logic                w_done;
    logic                w_try_inc;
    logic                w_latch_rca;
    logic                w_latch_hcs;
    logic [15:0]         w_rca_next;
`ifdef SD_INIT_RETRY_EN
    logic [1:0]          r_retry;
    logic                w_retry;
`endif

    assign w_terminal = (r_step == S_CMD0) ? TIMER_W'(CMD0_WAIT - 1)
                                           : TIMER_W'(RESP_TIMEOUT - 1);

    sd_timer #(.WIDTH(TIMER_W)) u_timer (
        .i_clk      (iclk),
        .i_rst_n    (irst),
        .i_clear    (r_state == ISSUE),
        .i_en       (r_state == WAIT),
        .i_terminal (w_terminal),
        .o_tc       (w_tc)
    );

    // Decide this cycle's transition; a response arriving on the timeout cycle wins.
    always_comb begin
        w_start     = 1'b0;
        w_issue     = 1'b0;
        w_next_step = r_step;
        w_fail      = 1'b0;
        w_code      = ERR_NONE;
        w_done      = 1'b0;
        w_try_inc   = 1'b0;
        w_latch_rca = 1'b0;
        w_latch_hcs = 1'b0;
`ifdef SD_INIT_RETRY_EN
        w_retry     = 1'b0;
`endif
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (bus.istart) begin
                    w_start     = 1'b1;
                    w_issue     = 1'b1;
                    w_next_step = S_CMD0;
                end
            end
            WAIT: begin
                if (r_step == S_CMD0) begin
                    if (w_tc) begin
                        w_issue     = 1'b1;
                        w_next_step = S_CMD8;
                    end
                end else if (bus.ivalid) begin
                    if (bus.icrc_fail && r_step != S_CMD2 && r_step != S_ACMD41) begin
                        w_fail = 1'b1;
                        w_code = ERR_CRC;
                    end else begin
                        case (r_step)
                            S_CMD8: begin
                                if (bus.iresp[11:0] != 12'h1AA) begin
                                    w_fail = 1'b1;
                                    w_code = ERR_ECHO;
                                end else begin
                                    w_issue     = 1'b1;
                                    w_next_step = S_CMD55;
                                end
                            end
                            S_CMD55: begin
                                w_issue     = 1'b1;
                                w_next_step = S_ACMD41;
                            end
                            S_ACMD41: begin
                                if (bus.iresp[31]) begin
                                    w_latch_hcs = 1'b1;
                                    w_issue     = 1'b1;
                                    w_next_step = S_CMD2;
                                end else if (r_try == TRY_W'(ACMD41_TRIES - 1)) begin
                                    w_fail = 1'b1;
                                    w_code = ERR_ACMD41;
                                end else begin
                                    w_try_inc   = 1'b1;
                                    w_issue     = 1'b1;
                                    w_next_step = S_CMD55;
                                end
                            end
                            S_CMD2: begin
                                w_issue     = 1'b1;
                                w_next_step = S_CMD3;
                            end
                            S_CMD3: begin
                                w_latch_rca = 1'b1;
                                w_issue     = 1'b1;
                                w_next_step = S_CMD7;
                            end
                            S_CMD7: w_done = 1'b1;
                            default: ;
                        endcase
                    end
                end else if (w_tc) begin
                    w_fail = 1'b1;
                    w_code = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
`ifdef SD_INIT_RETRY_EN
        if (w_fail && (w_code == ERR_TIMEOUT || w_code == ERR_CRC) && r_retry != 2'd3) begin
            w_fail  = 1'b0;
            w_retry = 1'b1;
            w_issue = 1'b1;
        end
`endif
    end

    assign w_rca_next = w_latch_rca ? bus.iresp[31:16] : r_rca;

    always_comb begin
        case (w_next_step)
            S_CMD8:   w_next_arg = CMD8_ARG;
            S_CMD55:  w_next_arg = {r_rca, 16'h0};
            S_ACMD41: w_next_arg = ACMD41_ARG;
            S_CMD7:   w_next_arg = {w_rca_next, 16'h0};
            default:  w_next_arg = 32'h0;
        endcase
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            r_state     <= IDLE;
            r_step      <= S_CMD0;
            r_ostart    <= 1'b0;
            r_sel_clk   <= 1'b0;
            r_cmd_index <= '0;
            r_cmd_arg   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_rca       <= '0;
            r_hcs       <= 1'b0;
            r_try       <= '0;
        end else begin
            r_ostart <= w_issue;
            if (w_start) begin
                r_sel_clk  <= 1'b0;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
                r_err_code <= ERR_NONE;
                r_rca      <= '0;
                r_hcs      <= 1'b0;
                r_try      <= '0;
            end
            if (w_issue) begin
                r_state     <= ISSUE;
                r_step      <= w_next_step;
                r_cmd_index <= cmd_index(w_next_step);
                r_cmd_arg   <= w_next_arg;
                r_busy      <= 1'b1;
            end else if (w_fail) begin
                r_state    <= ERROR;
                r_busy     <= 1'b0;
                r_error    <= 1'b1;
                r_err_code <= w_code;
            end else if (w_done) begin
                r_state   <= DONE;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_sel_clk <= 1'b1;
            end else if (r_state == ISSUE) begin
                r_state <= WAIT;
            end
            if (w_latch_rca) begin
                r_rca <= bus.iresp[31:16];
            end
            if (w_latch_hcs) begin
                r_hcs <= bus.iresp[30];
            end
            if (w_try_inc) begin
                r_try <= r_try + 1'b1;
            end
        end
    end

`ifdef SD_INIT_RETRY_EN
    // Retry budget is per step: any forward step (or a fresh start) refills it.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            r_retry <= 2'd0;
        end else if (w_retry) begin
            r_retry <= r_retry + 2'd1;
        end else if (w_issue) begin
            r_retry <= 2'd0;
        end
    end
`endif

    assign bus.ostart     = r_ostart;
    assign bus.osel_clk   = r_sel_clk;
    assign bus.ocmd_index = r_cmd_index;
    assign bus.ocmd_arg   = r_cmd_arg;
    assign bus.obusy      = r_busy;
    assign bus.odone      = r_done;
    assign bus.oerror     = r_error;
    assign bus.oerr_code  = r_err_code;
    assign bus.orca       = r_rca;
    assign bus.ohcs       = r_hcs;
endmodule

// File: tb/tb_sd_init_fsm.sv
// Directed self-checking bench for sd_init_fsm with a scripted card model.
// Honours SD_INIT_RETRY_EN when the design is built with it.
module tb_sd_init_fsm;
    import sd_pkg::*;

    localparam int          RT    = 4096;
    localparam int          C0W   = 64;
    localparam int          TRIES = 4;
    localparam logic [31:0] A41   = 32'h40FF_8000;
`ifdef SD_INIT_RETRY_EN
    localparam int          RETRIES = 3;
`else
    localparam int          RETRIES = 0;
`endif

    logic iclk = 1'b0;
    logic irst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 iclk = ~iclk;

    sd_init_fsm_if bus();

    sd_init_fsm #(
        .RESP_TIMEOUT (RT),
        .CMD0_WAIT    (C0W),
        .ACMD41_TRIES (TRIES),
        .ACMD41_ARG   (A41)
    ) dut (
        .iclk (iclk),
        .irst (irst),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic pulseStart();
        bus.istart = 1'b1;
        tick();
        bus.istart = 1'b0;
    endtask

    // Looks at the current cycle first, then steps until ostart or the budget runs out.
    task automatic nextCmd(input int budget, output logic [5:0] idx, output logic [31:0] arg,
                           output int cycles, output bit found);
        found  = 1'b0;
        cycles = 0;
        idx    = '0;
        arg    = '0;
        while (!found && cycles <= budget) begin
            if (bus.ostart === 1'b1) begin
                found = 1'b1;
                idx   = bus.ocmd_index;
                arg   = bus.ocmd_arg;
            end else begin
                tick();
                cycles++;
            end
        end
    endtask

    task automatic answer(input logic [31:0] resp, input logic crc, input int delay);
        tick();
        repeat (delay) tick();
        bus.iresp     = resp;
        bus.icrc_fail = crc;
        bus.ivalid    = 1'b1;
        tick();
        bus.ivalid    = 1'b0;
        bus.icrc_fail = 1'b0;
        bus.iresp     = '0;
    endtask

    task automatic test_reset();
        #2 irst = 1'b0;
        #1;
        checks++;
        if ({bus.ostart, bus.osel_clk, bus.obusy, bus.odone, bus.oerror} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 00000",
                     {bus.ostart, bus.osel_clk, bus.obusy, bus.odone, bus.oerror});
        end
        checks++;
        if ({bus.ocmd_index, bus.ocmd_arg} !== 38'h0) begin
            errors++;
            $display("[TB] FAIL reset_cmd: got %0h/%0h want 0/0", bus.ocmd_index, bus.ocmd_arg);
        end
        checks++;
        if ({bus.oerr_code, bus.orca, bus.ohcs} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset_status: got %0h want 0", {bus.oerr_code, bus.orca, bus.ohcs});
        end
        repeat (2) tick();
        @(negedge iclk) irst = 1'b1;
        repeat (5) tick();
        checks++;
        if ({bus.ostart, bus.obusy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %b want 00", {bus.ostart, bus.obusy});
        end
    endtask

    task automatic test_happy_path();
        logic [5:0]  expIdx [11];
        logic [31:0] expArg [11];
        logic [31:0] resp   [11];
        logic [5:0]  idx;
        logic [31:0] arg;
        int          cyc;
        bit          found;
        expIdx = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd2, 6'd3, 6'd7};
        expArg = '{32'h0, 32'h1AA, 32'h0, A41, 32'h0, A41, 32'h0, A41, 32'h0, 32'h0, 32'h1234_0000};
        resp   = '{32'h0, 32'h1AA, 32'h120, 32'h00FF_8000, 32'h120, 32'h00FF_8000, 32'h120,
                   32'h80FF_8000, 32'h0, 32'h1234_0500, 32'h700};
        pulseStart();
        for (int i = 0; i < 11; i++) begin
            nextCmd(RT + 16, idx, arg, cyc, found);
            checks++;
            if (!found || idx !== expIdx[i]) begin
                errors++;
                $display("[TB] FAIL happy_idx[%0d]: got %0d (seen=%0d) want %0d", i, idx, found, expIdx[i]);
            end
            checks++;
            if (arg !== expArg[i]) begin
                errors++;
                $display("[TB] FAIL happy_arg[%0d]: got %h want %h", i, arg, expArg[i]);
            end
            if (i == 1) begin
                checks++;
                if (cyc !== C0W - 1) begin
                    errors++;
                    $display("[TB] FAIL cmd0_wait: got %0d want %0d", cyc, C0W - 1);
                end
            end
            if (i == 3) begin
                checks++;
                if (bus.obusy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL busy_mid: got %b want 1", bus.obusy);
                end
            end
            if (i == 0) begin
                // istart while busy must not restart the sequence
                bus.istart = 1'b1;
                tick();
                bus.istart = 1'b0;
                tick();
            end else begin
                answer(resp[i], 1'b0, (i == 8) ? RT - 1 : 2);
            end
        end
        tick();
        checks++;
        if ({bus.odone, bus.osel_clk, bus.oerror, bus.obusy} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL happy_flags: got %b want 1100",
                     {bus.odone, bus.osel_clk, bus.oerror, bus.obusy});
        end
        checks++;
        if (bus.orca !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL happy_rca: got %h want 1234", bus.orca);
        end
        checks++;
        if (bus.ohcs !== 1'b0) begin
            errors++;
            $display("[TB] FAIL happy_hcs: got %b want 0", bus.ohcs);
        end
    endtask

    task automatic test_cmd8_mismatch();
        logic [5:0]  idx;
        logic [31:0] arg;
        int          cyc;
        bit          found;
        pulseStart();
        nextCmd(16, idx, arg, cyc, found);
        tick();
        nextCmd(C0W + 16, idx, arg, cyc, found);
        checks++;
        if (!found || idx !== CMD8) begin
            errors++;
            $display("[TB] FAIL echo_cmd8: got %0d want 8", idx);
        end
        answer(32'h0000_01AB, 1'b0, 3);
        checks++;
        if ({bus.oerror, bus.oerr_code, bus.obusy, bus.odone, bus.osel_clk} !== {1'b1, 3'd3, 3'b000}) begin
            errors++;
            $display("[TB] FAIL echo_error: got %b want 1011000",
                     {bus.oerror, bus.oerr_code, bus.obusy, bus.odone, bus.osel_clk});
        end
        nextCmd(200, idx, arg, cyc, found);
        checks++;
        if (found) begin
            errors++;
            $display("[TB] FAIL echo_quiet: got ostart with index %0d want none", idx);
        end
    endtask

    task automatic test_timeout();
        logic [5:0]  idx;
        logic [31:0] arg;
        int          cyc;
        int          starts;
        bit          found;
        pulseStart();
        nextCmd(16, idx, arg, cyc, found);
        tick();
        nextCmd(C0W + 16, idx, arg, cyc, found);
        checks++;
        if (!found || idx !== CMD8) begin
            errors++;
            $display("[TB] FAIL tmo_cmd8: got %0d want 8", idx);
        end
        cyc    = 0;
        starts = 1;
        while (bus.oerror !== 1'b1 && cyc < (RETRIES + 1) * (RT + 1) + 100) begin
            tick();
            cyc++;
            if (bus.ostart === 1'b1) starts++;
        end
        // each attempt is one ISSUE cycle plus RT wait cycles
        checks++;
        if (cyc !== (RETRIES + 1) * (RT + 1)) begin
            errors++;
            $display("[TB] FAIL tmo_cycles: got %0d want %0d", cyc, (RETRIES + 1) * (RT + 1));
        end
        checks++;
        if (starts !== RETRIES + 1) begin
            errors++;
            $display("[TB] FAIL tmo_starts: got %0d want %0d", starts, RETRIES + 1);
        end
        checks++;
        if ({bus.oerror, bus.oerr_code, bus.ocmd_index} !== {1'b1, 3'd1, CMD8}) begin
            errors++;
            $display("[TB] FAIL tmo_code: got err=%b code=%0d idx=%0d want 1/1/8",
                     bus.oerror, bus.oerr_code, bus.ocmd_index);
        end
    endtask

    task automatic test_crc();
        logic [5:0]  expIdx [7];
        logic [31:0] resp   [7];
        logic        crc    [7];
        logic [5:0]  idx;
        logic [31:0] arg;
        int          cyc;
        bit          found;
        expIdx = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd2, 6'd3, 6'd7};
        resp   = '{32'h0, 32'h1AA, 32'h120, 32'h80FF_8000, 32'h0, 32'h1234_0500, 32'h0};
        pulseStart();
        for (int i = 0; i < 5; i++) begin
            nextCmd(C0W + 16, idx, arg, cyc, found);
            checks++;
            if (!found || idx !== expIdx[i]) begin
                errors++;
                $display("[TB] FAIL crc3_idx[%0d]: got %0d want %0d", i, idx, expIdx[i]);
            end
            if (i == 0) tick();
            else answer(resp[i], 1'b0, 1);
        end
        for (int r = 0; r <= RETRIES; r++) begin
            nextCmd(16, idx, arg, cyc, found);
            checks++;
            if (!found || idx !== CMD3) begin
                errors++;
                $display("[TB] FAIL crc3_try[%0d]: got %0d want 3", r, idx);
            end
            answer(32'h1234_0500, 1'b1, 1);
        end
        checks++;
        if ({bus.oerror, bus.oerr_code, bus.odone, bus.orca} !== {1'b1, 3'd2, 1'b0, 16'h0}) begin
            errors++;
            $display("[TB] FAIL crc3_error: got err=%b code=%0d done=%b rca=%h want 1/2/0/0000",
                     bus.oerror, bus.oerr_code, bus.odone, bus.orca);
        end

        // ACMD41 and CMD2 carry no checkable CRC, so a flagged CRC must be ignored there
        resp = '{32'h0, 32'h1AA, 32'h120, 32'hC0FF_8000, 32'h0, 32'hABCD_0000, 32'h0};
        crc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        pulseStart();
        for (int i = 0; i < 7; i++) begin
            nextCmd(C0W + 16, idx, arg, cyc, found);
            checks++;
            if (!found || idx !== expIdx[i]) begin
                errors++;
                $display("[TB] FAIL crc41_idx[%0d]: got %0d want %0d", i, idx, expIdx[i]);
            end
            if (i == 6) begin
                checks++;
                if (arg !== 32'hABCD_0000) begin
                    errors++;
                    $display("[TB] FAIL crc41_cmd7_arg: got %h want abcd0000", arg);
                end
            end
            if (i == 0) tick();
            else answer(resp[i], crc[i], 0);
        end
        checks++;
        if ({bus.odone, bus.oerror, bus.ohcs, bus.orca} !== {3'b101, 16'hABCD}) begin
            errors++;
            $display("[TB] FAIL crc41_done: got done=%b err=%b hcs=%b rca=%h want 1/0/1/abcd",
                     bus.odone, bus.oerror, bus.ohcs, bus.orca);
        end
    endtask

    task automatic test_acmd41_exhaust();
        logic [5:0]  idx;
        logic [31:0] arg;
        int          cyc;
        bit          found;
        pulseStart();
        nextCmd(16, idx, arg, cyc, found);
        tick();
        nextCmd(C0W + 16, idx, arg, cyc, found);
        answer(32'h1AA, 1'b0, 1);
        for (int t = 0; t < TRIES; t++) begin
            nextCmd(16, idx, arg, cyc, found);
            checks++;
            if (!found || idx !== CMD55) begin
                errors++;
                $display("[TB] FAIL exh_cmd55[%0d]: got %0d want 55", t, idx);
            end
            answer(32'h120, 1'b0, 1);
            nextCmd(16, idx, arg, cyc, found);
            checks++;
            if (!found || idx !== ACMD41) begin
                errors++;
                $display("[TB] FAIL exh_acmd41[%0d]: got %0d want 41", t, idx);
            end
            answer(32'h00FF_8000, 1'b0, 1);
        end
        checks++;
        if ({bus.oerror, bus.oerr_code, bus.obusy} !== {1'b1, 3'd4, 1'b0}) begin
            errors++;
            $display("[TB] FAIL exh_code: got err=%b code=%0d busy=%b want 1/4/0",
                     bus.oerror, bus.oerr_code, bus.obusy);
        end
        nextCmd(100, idx, arg, cyc, found);
        checks++;
        if (found) begin
            errors++;
            $display("[TB] FAIL exh_quiet: got ostart with index %0d want none", idx);
        end
    endtask

    task automatic test_reset_restart();
        logic [5:0]  idx;
        logic [31:0] arg;
        int          cyc;
        bit          found;
        pulseStart();
        nextCmd(16, idx, arg, cyc, found);
        tick();
        nextCmd(C0W + 16, idx, arg, cyc, found);
        answer(32'h1AA, 1'b0, 1);
        nextCmd(16, idx, arg, cyc, found);
        answer(32'h120, 1'b0, 1);
        nextCmd(16, idx, arg, cyc, found);
        checks++;
        if (!found || idx !== ACMD41) begin
            errors++;
            $display("[TB] FAIL rst_pre_idx: got %0d want 41", idx);
        end
        repeat (2) tick();
        #2 irst = 1'b0;
        #1;
        checks++;
        if ({bus.ocmd_index, bus.ocmd_arg} !== 38'h0) begin
            errors++;
            $display("[TB] FAIL rst_async_cmd: got %0d/%h want 0/0", bus.ocmd_index, bus.ocmd_arg);
        end
        checks++;
        if ({bus.obusy, bus.ostart, bus.odone, bus.oerror, bus.osel_clk, bus.oerr_code, bus.ohcs} !== 9'h0) begin
            errors++;
            $display("[TB] FAIL rst_async_flags: got busy=%b start=%b done=%b err=%b code=%0d",
                     bus.obusy, bus.ostart, bus.odone, bus.oerror, bus.oerr_code);
        end
        @(negedge iclk) irst = 1'b1;
        tick();
        nextCmd(100, idx, arg, cyc, found);
        checks++;
        if (found) begin
            errors++;
            $display("[TB] FAIL rst_quiet: got ostart with index %0d want none", idx);
        end
        pulseStart();
        nextCmd(16, idx, arg, cyc, found);
        checks++;
        if (!found || idx !== CMD0) begin
            errors++;
            $display("[TB] FAIL rst_restart_idx: got %0d want 0", idx);
        end
        tick();
        nextCmd(C0W + 16, idx, arg, cyc, found);
        answer(32'h1AA, 1'b0, 1);
        nextCmd(16, idx, arg, cyc, found);
        checks++;
        if (!found || idx !== CMD55 || arg !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_cmd55: got %0d/%h want 55/00000000", idx, arg);
        end
    endtask

    initial begin
        bus.istart    = 1'b0;
        bus.iresp     = '0;
        bus.icrc_fail = 1'b0;
        bus.ivalid    = 1'b0;
        test_reset();
        test_happy_path();
        test_cmd8_mismatch();
        test_timeout();
        test_crc();
        test_acmd41_exhaust();
        test_reset_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
